// File: rtl/game_pkg.sv
// Shared types and constants for the flappy-bird game sequencer and its
// neighbouring blocks (score, physics, draw layers).
package game_pkg;

  localparam int unsigned RGB_W = 12;

  // Game phase as seen on the phase output; 2'b11 is never produced.
  typedef enum logic [1:0] {
    START = 2'd0,
    PLAY  = 2'd1,
    DEAD  = 2'd2
  } phase_t;

  localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;
  localparam logic [RGB_W-1:0] RGB_SKY   = 12'h4CF;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle between the game sequencer and its surroundings: frame/button/
// collision events, the three draw layers in, and pixel/phase/control out.
// slave = the sequencer, master = whatever drives the layers and consumes
// the outputs.
interface game_flow_ctrl_if;
  import game_pkg::*;

  logic             frame_start;
  logic             btn;
  logic             collision;
  logic [RGB_W-1:0] start_rgb;
  logic             start_valid;
  logic [RGB_W-1:0] game_rgb;
  logic             game_valid;
  logic [RGB_W-1:0] over_rgb;
  logic             over_valid;
  logic [RGB_W-1:0] rgb;
  phase_t           phase;
  logic             run;
  logic             restart;

  modport slave (
    input  frame_start, btn, collision,
    input  start_rgb, start_valid, game_rgb, game_valid, over_rgb, over_valid,
    output rgb, phase, run, restart
  );

  modport master (
    output frame_start, btn, collision,
    output start_rgb, start_valid, game_rgb, game_valid, over_rgb, over_valid,
    input  rgb, phase, run, restart
  );

endinterface

// File: rtl/game_flow_ctrl_frame_evt_latch.sv
// Frame-aligned event capture: button rising-edge detect folded into a
// once-per-frame request flag, plus a sticky collision latch. Shared with
// the score block.
module frame_evt_latch (
  input  logic clk,
  input  logic rst,
  input  logic frame_start_i,
  input  logic btn_i,
  input  logic collision_i,
  input  logic in_play_i,
  input  logic phase_chg_i,
  output logic pend_o,
  output logic col_latch_o
);

  logic btn_q;
  logic pend_q, pend_d;
  logic col_q, col_d;
  logic btn_rise;

  assign btn_rise = btn_i & ~btn_q;

  // Every frame_start consumes the pending request; a rise in that same
  // cycle becomes the request for the following frame.
  always_comb begin
    pend_d = frame_start_i ? btn_rise : (pend_q | btn_rise);
    col_d  = phase_chg_i ? 1'b0 : (col_q | (collision_i & in_play_i));
  end

  // Event state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q  <= 1'b0;
      pend_q <= 1'b0;
      col_q  <= 1'b0;
    end else begin
      btn_q  <= btn_i;
      pend_q <= pend_d;
      col_q  <= col_d;
    end
  end

  assign pend_o      = pend_q;
  assign col_latch_o = col_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-phase sequencer (START/PLAY/DEAD) and final pixel layer mux.
// Phase changes happen only on frame_start so frames are never torn.
// Optional macro GAME_FLOW_TIMEOUT_EN: DEAD falls back to START after
// TIMEOUT_FRAMES frames without an accepted press.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned      DEAD_FRAMES    = 60,
  parameter int unsigned      TIMEOUT_FRAMES = 600,
  parameter logic [RGB_W-1:0] BG_RGB         = RGB_SKY
) (
  input logic             clk,
  input logic             rst,
  game_flow_ctrl_if.slave bus
);

  localparam logic [1:0] PH_START = START;
  localparam logic [1:0] PH_PLAY  = PLAY;
  localparam logic [1:0] PH_DEAD  = DEAD;

  localparam logic [7:0] DEAD_LIM = DEAD_FRAMES[7:0];

  logic [1:0]       phase_q, phase_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             restart_q, restart_d;
  logic             run_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             pend;
  logic             col_latch;
  logic             phase_chg;

`ifdef GAME_FLOW_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_FRAMES - 1);
  logic [9:0] tcnt_q, tcnt_d;
`else
  // Keeps the parameter referenced when the timeout is compiled out.
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_FRAMES != 0);
`endif

  frame_evt_latch u_evt (
    .clk          (clk),
    .rst          (rst),
    .frame_start_i(bus.frame_start),
    .btn_i        (bus.btn),
    .collision_i  (bus.collision),
    .in_play_i    (phase_q == PH_PLAY),
    .phase_chg_i  (phase_chg),
    .pend_o       (pend),
    .col_latch_o  (col_latch)
  );

  // Next phase and counters, evaluated only at frame boundaries.
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    restart_d = 1'b0;
`ifdef GAME_FLOW_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif
    if (bus.frame_start) begin
      case (phase_q)
        PH_START: begin
          if (pend) begin
            phase_d   = PH_PLAY;
            restart_d = 1'b1;
          end
        end
        PH_PLAY: begin
          if (col_latch) begin
            phase_d = PH_DEAD;
            cnt_d   = '0;
`ifdef GAME_FLOW_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
        PH_DEAD: begin
          if (cnt_q != '1) cnt_d = cnt_q + 8'd1;
`ifdef GAME_FLOW_TIMEOUT_EN
          if (tcnt_q != '1) tcnt_d = tcnt_q + 10'd1;
`endif
          // Hold decision uses the count before this frame's increment.
          if (pend && (cnt_q >= DEAD_LIM)) phase_d = PH_START;
`ifdef GAME_FLOW_TIMEOUT_EN
          else if (tcnt_q >= TO_LAST) phase_d = PH_START;
`endif
        end
        default: phase_d = PH_START;
      endcase
    end
  end

  assign phase_chg = (phase_d != phase_q);

  // Layer selection for the current phase; registered below.
  always_comb begin
    rgb_d = BG_RGB;
    case (phase_q)
      PH_START: rgb_d = bus.start_valid ? bus.start_rgb : BG_RGB;
      PH_PLAY:  rgb_d = bus.game_valid ? bus.game_rgb : BG_RGB;
      PH_DEAD: begin
        if (bus.over_valid)      rgb_d = bus.over_rgb;
        else if (bus.game_valid) rgb_d = bus.game_rgb;
        else                     rgb_d = BG_RGB;
      end
      default: rgb_d = BG_RGB;
    endcase
  end

  // Phase, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_START;
      cnt_q     <= '0;
      restart_q <= 1'b0;
      run_q     <= 1'b0;
      rgb_q     <= RGB_BLACK;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
      run_q     <= (phase_d == PH_PLAY);
      rgb_q     <= rgb_d;
    end
  end

`ifdef GAME_FLOW_TIMEOUT_EN
  // Timeout frame counter.
  always_ff @(posedge clk) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end
`endif

  assign bus.phase   = phase_t'(phase_q);
  assign bus.rgb     = rgb_q;
  assign bus.run     = run_q;
  assign bus.restart = restart_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl (DEAD_FRAMES=4, TIMEOUT_FRAMES=8).
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam logic [11:0] CS  = 12'hA01;
  localparam logic [11:0] CG  = 12'h0B2;
  localparam logic [11:0] CO  = 12'hC03;
  localparam logic [11:0] CBG = 12'h4CF;

  typedef struct {
    logic        sv, gv, ov;
    logic [11:0] e_start, e_play, e_dead;
  } mux_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   restart_cnt = 0;
  logic [11:0] exp_q[$];
  mux_vec_t vec[8];

  game_flow_ctrl_if bus();

  game_flow_ctrl #(
    .DEAD_FRAMES   (4),
    .TIMEOUT_FRAMES(8),
    .BG_RGB        (12'h4CF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.restart === 1'b1) restart_cnt <= restart_cnt + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fs_pulse();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic press();
    bus.btn = 1'b1;
    tick();
    bus.btn = 1'b0;
    tick();
  endtask

  task automatic set_layers(input logic sv, input logic gv, input logic ov);
    bus.start_valid = sv;
    bus.game_valid  = gv;
    bus.over_valid  = ov;
  endtask

  // col: 0=START, 1=PLAY, 2=DEAD expectations
  task automatic apply_table(input int col);
    for (int i = 0; i < 8; i++) begin
      set_layers(vec[i].sv, vec[i].gv, vec[i].ov);
      case (col)
        0:       exp_q.push_back(vec[i].e_start);
        1:       exp_q.push_back(vec[i].e_play);
        default: exp_q.push_back(vec[i].e_dead);
      endcase
      tick();
      check($sformatf("mux_p%0d_v%0d", col, i), 16'(bus.rgb), 16'(exp_q.pop_front()));
    end
    set_layers(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vec[0] = '{1'b0, 1'b0, 1'b0, CBG, CBG, CBG};
    vec[1] = '{1'b1, 1'b0, 1'b0, CS,  CBG, CBG};
    vec[2] = '{1'b0, 1'b1, 1'b0, CBG, CG,  CG };
    vec[3] = '{1'b0, 1'b0, 1'b1, CBG, CBG, CO };
    vec[4] = '{1'b1, 1'b1, 1'b0, CS,  CG,  CG };
    vec[5] = '{1'b1, 1'b0, 1'b1, CS,  CBG, CO };
    vec[6] = '{1'b0, 1'b1, 1'b1, CBG, CG,  CO };
    vec[7] = '{1'b1, 1'b1, 1'b1, CS,  CG,  CO };

    bus.frame_start = 1'b0;
    bus.btn         = 1'b0;
    bus.collision   = 1'b0;
    bus.start_rgb   = CS;
    bus.game_rgb    = CG;
    bus.over_rgb    = CO;
    set_layers(1'b1, 1'b1, 1'b1);

    // Reset state
    idle(3);
    check("rst_phase", 16'(bus.phase), 16'(START));
    check("rst_rgb", 16'(bus.rgb), 16'h000);
    check("rst_run", 16'(bus.run), 16'd0);
    check("rst_restart", 16'(bus.restart), 16'd0);
    rst = 1'b0;
    set_layers(1'b0, 1'b0, 1'b0);

    // Idle frames stay in START; mux in START
    for (int f = 0; f < 3; f++) begin
      fs_pulse();
      idle(6);
    end
    check("idle_start", 16'(bus.phase), 16'(START));
    apply_table(0);

    // Mid-frame press acts at next frame_start
    press();
    idle(2);
    check("press_wait", 16'(bus.phase), 16'(START));
    fs_pulse();
    check("press_play", 16'(bus.phase), 16'(PLAY));
    check("press_restart", 16'(bus.restart), 16'd1);
    check("press_run", 16'(bus.run), 16'd1);
    tick();
    check("restart_1cyc", 16'(bus.restart), 16'd0);
    check("restart_cnt1", 16'(restart_cnt), 16'd1);

    // Mux in PLAY, then one-cycle latency
    apply_table(1);
    set_layers(1'b0, 1'b1, 1'b0);
    tick();
    check("lat_pre", 16'(bus.rgb), 16'(CG));
    bus.game_valid = 1'b0;
    #1;
    check("lat_hold", 16'(bus.rgb), 16'(CG));
    tick();
    check("lat_bg", 16'(bus.rgb), 16'(CBG));
    bus.game_valid = 1'b1;
    tick();
    check("lat_back", 16'(bus.rgb), 16'(CG));

    // Collision mid-frame
    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
    idle(2);
    check("col_wait", 16'(bus.phase), 16'(PLAY));
    fs_pulse();
    check("col_dead", 16'(bus.phase), 16'(DEAD));
    check("col_run", 16'(bus.run), 16'd0);
    tick();
    check("dead_game_under", 16'(bus.rgb), 16'(CG));
    apply_table(2);

    // DEAD hold: presses in frames 1 and 3 ignored, frame 5 accepted
    for (int k = 1; k <= 5; k++) begin
      fs_pulse();
      check($sformatf("hold_f%0d", k), 16'(bus.phase), 16'(DEAD));
      if (k % 2 == 1) press();
      idle(3);
    end
    fs_pulse();
    check("hold_exit", 16'(bus.phase), 16'(START));
    check("hold_norestart", 16'(bus.restart), 16'd0);
    tick();
    check("restart_cnt_hold", 16'(restart_cnt), 16'd1);

    // Rise coincident with frame_start defers; held btn gives one transition
    bus.btn = 1'b1;
    fs_pulse();
    check("coinc_btn_start", 16'(bus.phase), 16'(START));
    idle(3);
    fs_pulse();
    check("coinc_btn_play", 16'(bus.phase), 16'(PLAY));
    for (int f = 0; f < 2; f++) begin
      idle(4);
      fs_pulse();
    end
    check("held_play", 16'(bus.phase), 16'(PLAY));
    check("restart_cnt_held", 16'(restart_cnt), 16'd2);

    // Collision coincident with frame_start acts one frame later
    bus.collision = 1'b1;
    fs_pulse();
    bus.collision = 1'b0;
    check("coinc_col_play", 16'(bus.phase), 16'(PLAY));
    bus.btn = 1'b0;
    idle(3);
    fs_pulse();
    check("coinc_col_dead", 16'(bus.phase), 16'(DEAD));

    // Timeout behaviour
    for (int k = 1; k <= 20; k++) begin
      fs_pulse();
`ifdef GAME_FLOW_TIMEOUT_EN
      check($sformatf("to_f%0d", k), 16'(bus.phase), (k < 8) ? 16'(DEAD) : 16'(START));
`else
      check($sformatf("noto_f%0d", k), 16'(bus.phase), 16'(DEAD));
`endif
      idle(3);
    end
    check("to_restart_cnt", 16'(restart_cnt), 16'd2);

    // Reset while in PLAY
    rst = 1'b1;
    tick();
    rst = 1'b0;
    press();
    fs_pulse();
    check("rst2_play", 16'(bus.phase), 16'(PLAY));
    set_layers(1'b0, 1'b1, 1'b0);
    idle(2);
    check("rst2_rgb_pre", 16'(bus.rgb), 16'(CG));
    rst = 1'b1;
    tick();
    check("rstp_phase", 16'(bus.phase), 16'(START));
    check("rstp_run", 16'(bus.run), 16'd0);
    check("rstp_rgb", 16'(bus.rgb), 16'h000);
    check("rstp_restart", 16'(bus.restart), 16'd0);
    rst = 1'b0;
    idle(2);
    check("restart_cnt_final", 16'(restart_cnt), 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
